// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, FSM encoding and op decode helpers for alu_arbiter
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SUBU = 4'b1011;
    localparam logic [3:0] OP_ADDU = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // The ALU overflow flag is sticky, so it only means something for these ops
    function automatic logic ovf_valid(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SUBU, OP_ADDU: ovf_valid = 1'b1;
            default:                          ovf_valid = 1'b0;
        endcase
    endfunction

    function automatic logic undef_op(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b1110, 4'b1111: undef_op = 1'b1;
            default:                            undef_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-way grant logic; ALU_ARB_FIXED_PRIO_EN selects fixed priority
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 always wins a tie
    always_comb begin
        grant0 = req0;
        grant1 = req1 & ~req0;
    end
`else
    // last_q high means requester 1 was granted last, so requester 0 is favoured
    logic last_q;
    logic last_d;

    // Tie goes to the requester not granted last; a lone requester always wins
    always_comb begin
        grant0 = req0;
        grant1 = req1;
        if (req0 && req1) begin
            grant0 = last_q;
            grant1 = ~last_q;
        end
    end

    // Pointer moves only when a grant is actually taken
    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant1;
        end
    end

    // Pointer register; reset favours requester 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered-result ALU between two requesters (option: ALU_ARB_FIXED_PRIO_EN)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [OP_W-1:0]    req0_op,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [OP_W-1:0]    req1_op,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_zero,
    output logic               rsp_ovf,
    output logic               rsp_err,
    output logic [OP_W-1:0]    alu_control,
    output logic [DATA_W-1:0]  operand_A,
    output logic [DATA_W-1:0]  operand_B,
    output logic [SHAMT_W-1:0] shmant,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               zero_flag,
    input  logic               overflow
);

    state_e state_q, state_d;

    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               owner_q, owner_d;

    logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;

    logic idle;
    logic accept;
    logic grant0;
    logic grant1;
    logic err;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle & (req0_valid | req1_valid);
    assign err    = undef_op(op_q);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept in IDLE, then one cycle for the ALU to register and one to collect it
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:    state_d = accept ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Ready is the grant qualified by IDLE; it never looks at response state
    always_comb begin
        req0_ready = idle & grant0;
        req1_ready = idle & grant1;
    end

    // Request latch on acceptance and response latch on leaving CAPTURE
    always_comb begin
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        shamt_d      = shamt_q;
        owner_d      = owner_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        if (accept) begin
            owner_d = grant1;
            if (grant1) begin
                op_d    = req1_op;
                a_d     = req1_a;
                b_d     = req1_b;
                shamt_d = req1_shamt;
            end else begin
                op_d    = req0_op;
                a_d     = req0_a;
                b_d     = req0_b;
                shamt_d = req0_shamt;
            end
        end
        if (state_q == ST_CAPTURE) begin
            rsp_err_d    = err;
            rsp_result_d = err ? '0 : alu_result;
            rsp_zero_d   = err ? 1'b1 : zero_flag;
            rsp_ovf_d    = ~err & ovf_valid(op_q) & overflow;
            rsp0_valid_d = ~owner_q;
            rsp1_valid_d = owner_q;
        end
    end

    // Datapath registers; reset drops any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            shamt_q      <= '0;
            owner_q      <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shamt_q      <= shamt_d;
            owner_q      <= owner_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign alu_control = op_q;
    assign operand_A   = a_q;
    assign operand_B   = b_q;
    assign shmant      = shamt_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_err     = rsp_err_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a registered ALU model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tv [2];
    logic [3:0]  top [2];
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    logic [4:0]  tsh [2];
    logic        held [2];

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_ovf, rsp_err;
    logic [3:0]  alu_control;
    logic [31:0] operand_A, operand_B;
    logic [4:0]  shmant;
    logic [31:0] alu_res;
    logic        alu_z, alu_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: cycles into the operation (0 = free), pointer, latched op, response regs
    int          m_cnt;
    int          m_last;
    int          m_owner;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_sh;
    logic [31:0] m_res;
    logic        m_z, m_o, m_e, m_p0, m_p1;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(tv[0]), .req0_ready(req0_ready), .req0_op(top[0]),
        .req0_a(ta[0]), .req0_b(tb[0]), .req0_shamt(tsh[0]),
        .req1_valid(tv[1]), .req1_ready(req1_ready), .req1_op(top[1]),
        .req1_a(ta[1]), .req1_b(tb[1]), .req1_shamt(tsh[1]),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_control(alu_control), .operand_A(operand_A), .operand_B(operand_B), .shmant(shmant),
        .alu_result(alu_res), .zero_flag(alu_z), .overflow(alu_o)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'b0010, 4'b1100: alu_fn = a + b;
            4'b0011, 4'b1011: alu_fn = a - b;
            4'b0100: alu_fn = a & b;
            4'b0101: alu_fn = a | b;
            4'b0110: alu_fn = a ^ b;
            4'b0111: alu_fn = ~a;
            4'b1000: alu_fn = a << sh;
            4'b1001: alu_fn = a >> sh;
            4'b1010: alu_fn = ~(a | b);
            4'b1101: alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: alu_fn = a ^ b ^ 32'h5A5A_DEAD;
        endcase
    endfunction

    function automatic logic ovf_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            4'b0010: ovf_fn = (a[31] == b[31]) && (s[31] != a[31]);
            4'b0011: ovf_fn = (a[31] != b[31]) && (((a - b) >> 31) != {31'd0, a[31]});
            4'b1100: ovf_fn = s[32];
            4'b1011: ovf_fn = (a < b);
            default: ovf_fn = 1'b0;
        endcase
    endfunction

    function automatic logic is_undef(input logic [3:0] op);
        is_undef = (op == 4'd0) || (op == 4'd1) || (op == 4'd14) || (op == 4'd15);
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        is_arith = (op == 4'd2) || (op == 4'd3) || (op == 4'd11) || (op == 4'd12);
    endfunction

    // Registered ALU with a sticky overflow flag that only arithmetic ops update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_res <= '0;
            alu_z   <= 1'b0;
            alu_o   <= 1'b0;
        end else begin
            alu_res <= alu_fn(alu_control, operand_A, operand_B, shmant);
            alu_z   <= (alu_fn(alu_control, operand_A, operand_B, shmant) == 32'd0);
            if (is_arith(alu_control)) alu_o <= ovf_fn(alu_control, operand_A, operand_B);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_last = 1; m_owner = 0;
        m_op = '0; m_a = '0; m_b = '0; m_sh = '0;
        m_res = '0; m_z = 1'b0; m_o = 1'b0; m_e = 1'b0; m_p0 = 1'b0; m_p1 = 1'b0;
    endtask

    task automatic check_regs();
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_p0});
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_p1});
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_z});
        chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, m_o});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_e});
        chk("alu_control", {28'd0, alu_control}, {28'd0, m_op});
        chk("operand_A", operand_A, m_a);
        chk("operand_B", operand_B, m_b);
        chk("shmant", {27'd0, shmant}, {27'd0, m_sh});
    endtask

    // One clock: check ready against the inputs set since the last falling edge,
    // advance the model across the rising edge, then check the registered outputs.
    task automatic step();
        int g;
        #1;
        g = -1;
        if (m_cnt == 0) begin
            if (tv[0] && tv[1]) g = 1 - m_last;
            else if (tv[0])     g = 0;
            else if (tv[1])     g = 1;
        end
        chk("req0_ready", {31'd0, req0_ready}, (g == 0) ? 32'd1 : 32'd0);
        chk("req1_ready", {31'd0, req1_ready}, (g == 1) ? 32'd1 : 32'd0);
        if (reset) begin
            model_reset();
        end else if (m_cnt == 2) begin
            m_e   = is_undef(m_op);
            m_res = m_e ? 32'd0 : alu_fn(m_op, m_a, m_b, m_sh);
            m_z   = m_e ? 1'b1 : (alu_fn(m_op, m_a, m_b, m_sh) == 32'd0);
            m_o   = (!m_e && is_arith(m_op)) ? ovf_fn(m_op, m_a, m_b) : 1'b0;
            m_p0  = (m_owner == 0);
            m_p1  = (m_owner == 1);
            m_cnt = 0;
        end else begin
            m_p0 = 1'b0;
            m_p1 = 1'b0;
            if (m_cnt == 1) begin
                m_cnt = 2;
            end else if (g >= 0) begin
                m_op = top[g]; m_a = ta[g]; m_b = tb[g]; m_sh = tsh[g];
                m_owner = g; m_last = g; held[g] = 1'b0; m_cnt = 1;
            end
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        tv[n] = 1'b1; top[n] = op; ta[n] = a; tb[n] = b; tsh[n] = sh;
    endtask

    // Single request from a free arbiter; returns on the cycle its response is valid
    task automatic run1(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
        set_req(n, op, a, b, sh);
        step();
        tv[n] = 1'b0;
        step();
        step();
    endtask

    initial begin
        int owners [$];
        logic [31:0] results [$];
        for (int n = 0; n < 2; n++) begin
            tv[n] = 1'b0; top[n] = '0; ta[n] = '0; tb[n] = '0; tsh[n] = '0; held[n] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_regs();
        chk("reset_ready0", {31'd0, req0_ready}, 32'd0);
        reset = 1'b0;

        // both requesters held valid: owner 0 first, then strict alternation
        set_req(0, 4'b0010, 32'd1, 32'd1, 5'd0);
        set_req(1, 4'b0010, 32'd2, 32'd2, 5'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp0_valid) begin owners.push_back(0); results.push_back(rsp_result); end
            if (rsp1_valid) begin owners.push_back(1); results.push_back(rsp_result); end
        end
        chk("rr_count", owners.size(), 32'd4);
        for (int i = 0; i < owners.size() && i < 4; i++) begin
            chk("rr_owner", owners[i], (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_result", results[i], (i % 2 == 0) ? 32'd2 : 32'd4);
        end
        tv[0] = 1'b0; tv[1] = 1'b0;
        step();
        step();

        // ADD 5 + 7 on requester 0
        set_req(0, 4'b0010, 32'd5, 32'd7, 5'd0);
        #1;
        chk("add_ready_same_cycle", {31'd0, req0_ready}, 32'd1);
        tv[0] = 1'b0;
        run1(0, 4'b0010, 32'd5, 32'd7, 5'd0);
        chk("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("add_result", rsp_result, 32'd12);
        chk("add_zero", {31'd0, rsp_zero}, 32'd0);
        chk("add_ovf", {31'd0, rsp_ovf}, 32'd0);
        chk("add_err", {31'd0, rsp_err}, 32'd0);
        step();
        chk("add_pulse_one_cycle", {31'd0, rsp0_valid}, 32'd0);

        // SUB 7 - 7 on requester 1
        run1(1, 4'b0011, 32'd7, 32'd7, 5'd0);
        chk("sub_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("sub_result", rsp_result, 32'd0);
        chk("sub_zero", {31'd0, rsp_zero}, 32'd1);

        // unsigned carry sets the sticky flag; the following AND must not report it
        run1(0, 4'b1100, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("addu_ovf", {31'd0, rsp_ovf}, 32'd1);
        run1(0, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        chk("and_result", rsp_result, 32'hF000_F000);
        chk("and_ovf_masked", {31'd0, rsp_ovf}, 32'd0);

        // undefined op
        run1(0, 4'b1111, 32'd3, 32'd4, 5'd0);
        chk("undef_err", {31'd0, rsp_err}, 32'd1);
        chk("undef_result", rsp_result, 32'd0);
        chk("undef_zero", {31'd0, rsp_zero}, 32'd1);
        step();

        // reset while the operation sits in CAPTURE
        set_req(0, 4'b0010, 32'd9, 32'd9, 5'd3);
        step();
        tv[0] = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
        chk("rst_operand_A", operand_A, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        model_reset();
        step();
        step();
        reset = 1'b0;
        set_req(0, 4'b0101, 32'd1, 32'd2, 5'd0);
        #1;
        chk("post_rst_ready", {31'd0, req0_ready}, 32'd1);
        step();
        tv[0] = 1'b0;
        chk("post_rst_latched_op", {28'd0, alu_control}, 32'd5);
        chk("post_rst_latched_a", operand_A, 32'd1);
        step();
        step();
        chk("post_rst_or_result", rsp_result, 32'd3);
        step();

        // randomized traffic; each requester holds its request until it is taken
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!held[n]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        tv[n] = 1'b0;
                    end else begin
                        set_req(n, 4'($urandom_range(0, 15)),
                                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                                5'($urandom_range(0, 31)));
                        held[n] = 1'b1;
                    end
                end
            end
            step();
        end
        tv[0] = 1'b0; tv[1] = 1'b0;
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
